// File: rtl/time_set_controller.sv
// Push-button HH:MM editor feeding the alarm clock core's load interface.
// Optional TIMESET_AUTOREPEAT_EN: held btn_inc auto-repeats after REPEAT_DELAY cycles.
module time_set_controller #(
  parameter int unsigned TIMEOUT_S = 30
`ifdef TIMESET_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY = 2
`endif
) (
  input  logic       clock_1s,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic       target_alarm,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       editing,
  output logic [1:0] edit_digit
);

  typedef enum logic [2:0] {
    IDLE,
    SET_H1,
    SET_H0,
    SET_M1,
    SET_M0,
    COMMIT
  } state_t;

  localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

  state_t     state, state_n;
  logic       mode_q, inc_q, cancel_q;
  logic       target_q;
  logic [1:0] h1, h1_n;
  logic [3:0] h0, h0_n, m1, m1_n, m0, m0_n;
  logic [5:0] to_cnt;

  logic mode_p, inc_p, cancel_p, inc_ev;
  logic in_set, enter, advance, abort, do_inc, timeout_hit, any_act;
  logic [1:0] c_h1;
  logic [3:0] c_h0, c_m1, c_m0;

  assign mode_p   = btn_mode & ~mode_q;
  assign inc_p    = btn_inc & ~inc_q;
  assign cancel_p = btn_cancel & ~cancel_q;

`ifdef TIMESET_AUTOREPEAT_EN
  localparam logic [7:0] REP = 8'(REPEAT_DELAY);
  logic [7:0] rep_cnt;

  // rep_cnt counts consecutive high cycles of btn_inc, saturating at REP
  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset)
      rep_cnt <= '0;
    else if (!btn_inc)
      rep_cnt <= '0;
    else if (rep_cnt < REP)
      rep_cnt <= rep_cnt + 8'd1;
  end

  assign inc_ev = inc_p | (btn_inc & inc_q & (rep_cnt >= REP));
`else
  assign inc_ev = inc_p;
`endif

  assign in_set      = (state == SET_H1) || (state == SET_H0) ||
                       (state == SET_M1) || (state == SET_M0);
  assign any_act     = mode_p | cancel_p | inc_ev;
  assign timeout_hit = in_set && !any_act && (to_cnt == TO_LAST);
  assign enter       = (state == IDLE) && mode_p && !cancel_p;
  assign abort       = in_set && (cancel_p || timeout_hit);
  assign advance     = in_set && !cancel_p && mode_p;
  assign do_inc      = in_set && !cancel_p && !mode_p && inc_ev;

  // Out-of-range current time is clamped into 00:00..23:59 on copy
  assign c_h1 = (cur_hour1 > 2'd2) ? 2'd2 : cur_hour1;
  assign c_h0 = ((c_h1 == 2'd2) && (cur_hour0 > 4'd3)) ? 4'd3 :
                (cur_hour0 > 4'd9) ? 4'd9 : cur_hour0;
  assign c_m1 = (cur_min1 > 4'd5) ? 4'd5 : cur_min1;
  assign c_m0 = (cur_min0 > 4'd9) ? 4'd9 : cur_min0;

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enter) state_n = SET_H1;
      SET_H1:  if (abort) state_n = IDLE; else if (advance) state_n = SET_H0;
      SET_H0:  if (abort) state_n = IDLE; else if (advance) state_n = SET_M1;
      SET_M1:  if (abort) state_n = IDLE; else if (advance) state_n = SET_M0;
      SET_M0:  if (abort) state_n = IDLE; else if (advance) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    editing    = 1'b0;
    edit_digit = '0;
    load_time  = 1'b0;
    load_alarm = 1'b0;
    unique case (state)
      SET_H1: begin editing = 1'b1; edit_digit = 2'd0; end
      SET_H0: begin editing = 1'b1; edit_digit = 2'd1; end
      SET_M1: begin editing = 1'b1; edit_digit = 2'd2; end
      SET_M0: begin editing = 1'b1; edit_digit = 2'd3; end
      COMMIT: begin
        load_alarm = target_q;
        load_time  = ~target_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    h1_n = h1;
    h0_n = h0;
    m1_n = m1;
    m0_n = m0;
    if (enter) begin
      h1_n = c_h1;
      h0_n = c_h0;
      m1_n = c_m1;
      m0_n = c_m0;
    end else if (do_inc) begin
      unique case (state)
        SET_H1: begin
          h1_n = (h1 >= 2'd2) ? 2'd0 : h1 + 2'd1;
          // H0 must stay legal when the tens digit moves to 2
          if ((h1_n == 2'd2) && (h0 > 4'd3)) h0_n = 4'd3;
        end
        SET_H0: begin
          if (h1 == 2'd2) h0_n = (h0 >= 4'd3) ? 4'd0 : h0 + 4'd1;
          else            h0_n = (h0 >= 4'd9) ? 4'd0 : h0 + 4'd1;
        end
        SET_M1:  m1_n = (m1 >= 4'd5) ? 4'd0 : m1 + 4'd1;
        SET_M0:  m0_n = (m0 >= 4'd9) ? 4'd0 : m0 + 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      mode_q   <= 1'b0;
      inc_q    <= 1'b0;
      cancel_q <= 1'b0;
      target_q <= 1'b0;
      h1       <= '0;
      h0       <= '0;
      m1       <= '0;
      m0       <= '0;
      to_cnt   <= '0;
    end else begin
      mode_q   <= btn_mode;
      inc_q    <= btn_inc;
      cancel_q <= btn_cancel;
      if (enter) target_q <= target_alarm;
      h1 <= h1_n;
      h0 <= h0_n;
      m1 <= m1_n;
      m0 <= m0_n;
      if (!in_set || any_act || timeout_hit)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 6'd1;
    end
  end

  assign hour_in1   = h1;
  assign hour_in0   = h0;
  assign minute_in1 = m1;
  assign minute_in0 = m0;

endmodule
